bpsk_demodulator: RTL and testbench

Receive-side counterpart of the BPSK modulator. Takes one signed sample per enabled clock, carrier-synchronous at 2**ADDR_WIDTH samples per symbol. Correlates each symbol period against a square-wave reference, slices the sign into a bit, and assembles ADDR_WIDTH+1 bits into a parallel word. Sits between the ADC/channel model and the frame/word consumer.

---
 rtl/bpsk_demodulator.sv | 100 ++++++++++
 tb/tb_bpsk_demodulator.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/bpsk_demodulator.sv
// bpsk_demodulator: square-wave correlating BPSK slicer with LSB-first word assembly.
// Optional per-bit low-confidence flag enabled by defining BPSK_DEMOD_CONF_EN.
module bpsk_demodulator #(
  parameter int DATA_WIDTH  = 12,
  parameter int ADDR_WIDTH  = 8,
  parameter int CONF_THRESH = 4096
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         en,
  input  logic                         sync,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  output logic                         bit_out,
  output logic                         bit_valid,
  output logic [ADDR_WIDTH:0]          data_out,
  output logic                         word_valid,
  output logic                         low_conf
);
  localparam int ACC_W = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int BW = $clog2(ADDR_WIDTH + 1);
  typedef enum logic {ACQ, TRACK} state_t;
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   phase_q, phase_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum, sample_ext;
  logic [ADDR_WIDTH:0]     shift_q, shift_d, data_q, data_d;
  logic                    bit_q, bit_d, bit_valid_q, bit_valid_d, word_valid_q, word_valid_d;
  logic                    sym_end;
  assign sample_ext = {{(ADDR_WIDTH+1){sample_in[DATA_WIDTH-1]}}, sample_in};
  assign acc_sum = phase_q[ADDR_WIDTH-1] ? acc_q - sample_ext : acc_q + sample_ext;
  // sync outranks a coincident symbol end, so that symbol never produces a bit
  assign sym_end = state_q == TRACK && en && !sync && phase_q == '1;
  always_comb begin
    state_d      = sync ? TRACK : state_q;
    phase_d      = phase_q;
    bit_cnt_d    = bit_cnt_q;
    acc_d        = acc_q;
    shift_d      = shift_q;
    data_d       = data_q;
    bit_d        = bit_q;
    bit_valid_d  = 1'b0;
    word_valid_d = 1'b0;
    if (sync) begin
      phase_d   = ADDR_WIDTH'(en);
      bit_cnt_d = '0;
      acc_d     = en ? sample_ext : '0;
      shift_d   = '0;
    end else if (state_q == TRACK && en) begin
      phase_d = phase_q + 1'b1;
      acc_d   = sym_end ? '0 : acc_sum;
      if (sym_end) begin
        bit_d              = !acc_sum[ACC_W-1] && acc_sum != '0;
        bit_valid_d        = 1'b1;
        shift_d[bit_cnt_q] = bit_d;
        word_valid_d       = bit_cnt_q == BW'(ADDR_WIDTH);
        bit_cnt_d          = word_valid_d ? '0 : bit_cnt_q + 1'b1;
        data_d             = word_valid_d ? shift_d : data_q;
      end
    end
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ACQ;
      phase_q      <= '0;
      bit_cnt_q    <= '0;
      acc_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      bit_q        <= 1'b0;
      bit_valid_q  <= 1'b0;
      word_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      acc_q        <= acc_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      bit_q        <= bit_d;
      bit_valid_q  <= bit_valid_d;
      word_valid_q <= word_valid_d;
    end
  end
  assign bit_out    = bit_q;
  assign bit_valid  = bit_valid_q;
  assign data_out   = data_q;
  assign word_valid = word_valid_q;
`ifdef BPSK_DEMOD_CONF_EN
  localparam logic signed [ACC_W-1:0] THR = ACC_W'(CONF_THRESH);
  logic low_conf_q, low_conf_d;
  assign low_conf_d = sym_end ? (acc_sum < THR && acc_sum > -THR) : low_conf_q;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) low_conf_q <= 1'b0;
    else         low_conf_q <= low_conf_d;
  end
  assign low_conf = low_conf_q;
`else
  assign low_conf = 1'b0;
`endif
endmodule

// File: tb/tb_bpsk_demodulator.sv
// tb_bpsk_demodulator: directed frames plus randomized traffic against an integer-arithmetic model.
module tb_bpsk_demodulator;
  localparam int DW = 12, AW = 8, SPS = 256, THR = 4096;
  logic clk = 1'b0, arst_n = 1'b0, en = 1'b0, sync = 1'b0;
  logic signed [DW-1:0] sample_in = '0;
  logic bit_out, bit_valid, word_valid, low_conf;
  logic [AW:0] data_out;
  int n_pass = 0, n_chk = 0, n_bv = 0, n_wv = 0;
  bit m_track;
  int m_n, m_sum, m_k;
  logic [AW:0] m_part, m_data;
  logic m_bit, m_bv, m_wv, m_lc;

  bpsk_demodulator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CONF_THRESH(THR)) dut (
    .clk(clk), .arst_n(arst_n), .en(en), .sync(sync), .sample_in(sample_in),
    .bit_out(bit_out), .bit_valid(bit_valid), .data_out(data_out),
    .word_valid(word_valid), .low_conf(low_conf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int sine(input int n);
    return int'(2047.0 * $sin(2.0 * 3.14159265358979 * n / SPS));
  endfunction

  task automatic model_reset();
    m_track = 0; m_n = 0; m_sum = 0; m_k = 0;
    m_part = '0; m_data = '0; m_bit = 0; m_bv = 0; m_wv = 0; m_lc = 0;
  endtask

  task automatic model(input bit s_sync, input bit s_en, input int s);
    m_bv = 0; m_wv = 0;
    if (s_sync) begin
      m_track = 1; m_k = 0; m_part = '0;
      m_sum = s_en ? s : 0;
      m_n = s_en ? 1 : 0;
    end else if (m_track && s_en) begin
      m_sum += (m_n < SPS / 2) ? s : -s;
      m_n++;
      if (m_n == SPS) begin
        m_bit = m_sum > 0;
        m_bv = 1;
`ifdef BPSK_DEMOD_CONF_EN
        m_lc = (m_sum < 0 ? -m_sum : m_sum) < THR;
`endif
        m_part[m_k] = m_bit;
        m_k++;
        if (m_k == AW + 1) begin
          m_data = m_part; m_wv = 1; m_k = 0;
        end
        m_n = 0; m_sum = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("bit_valid", bit_valid, m_bv);
    chk("word_valid", word_valid, m_wv);
    chk("bit_out", bit_out, m_bit);
    chk("data_out", data_out, m_data);
    chk("low_conf", low_conf, m_lc);
  endtask

  task automatic step(input bit s_sync, input bit s_en, input int s);
    sync = s_sync; en = s_en; sample_in = DW'(s);
    @(posedge clk);
    model(s_sync, s_en, s);
    #1;
    check_all();
    if (bit_valid) n_bv++;
    if (word_valid) n_wv++;
  endtask

  task automatic do_reset();
    arst_n = 0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1;
  endtask

  task automatic send_frame(input logic [AW:0] w, input bit gap);
    int k = 0;
    n_bv = 0; n_wv = 0;
    for (int b = 0; b <= AW; b++)
      for (int n = 0; n < SPS; n++) begin
        if (gap && k % 3 == 2) begin step(0, 0, 0); k++; end
        step(b == 0 && n == 0, 1, w[b] ? sine(n) : -sine(n));
        k++;
      end
    chk("frame_word_valid", word_valid, 1);
    chk("frame_word", data_out, w);
    chk("frame_bit_pulses", n_bv, AW + 1);
    chk("frame_low_conf", low_conf, 0);
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();
    chk("rst_data", data_out, 0);
    n_bv = 0;
    for (int i = 0; i < 300; i++) step(0, 1, int'($urandom_range(0, 4095)) - 2048);
    chk("acq_no_bits", n_bv, 0);
    send_frame(9'h165, 0);
    send_frame(9'h165, 1);
    step(1, 1, sine(0));
    for (int i = 1; i < 4 * SPS + 100; i++) step(0, 1, sine(i % SPS));
    n_wv = 0;
    send_frame(9'h0AA, 0);
    chk("resync_one_word", n_wv, 1);
    step(1, 1, 0);
    for (int i = 1; i < SPS; i++) step(0, 1, 0);
    chk("zero_bv", bit_valid, 1);
    chk("zero_bit", bit_out, 0);
`ifdef BPSK_DEMOD_CONF_EN
    chk("zero_low_conf", low_conf, 1);
`else
    chk("zero_low_conf", low_conf, 0);
`endif
    step(1, 1, 2047);
    for (int i = 1; i < SPS - 1; i++) step(0, 1, 0);
    chk("bnd_no_early", bit_valid, 0);
    step(0, 1, 0);
    chk("bnd_bv", bit_valid, 1);
    chk("bnd_bit", bit_out, 1);
    begin
      int ph = 0, pol = 1, div = 1;
      for (int i = 0; i < 20000; i++) begin
        bit s_en = $urandom_range(0, 3) != 0;
        bit s_sync = $urandom_range(0, 1499) == 0;
        int s;
        if (i % 5000 == 4321) begin
          @(negedge clk);
          do_reset();
        end
        if (s_en && ph % SPS == 0) begin
          pol = $urandom_range(0, 1) ? 1 : -1;
          div = $urandom_range(1, 40);
        end
        s = pol * sine(ph % SPS) / div + int'($urandom_range(0, 600)) - 300;
        s = s > 2047 ? 2047 : (s < -2048 ? -2048 : s);
        if (s_en) ph++;
        if (s_sync) ph = s_en ? 1 : 0;
        step(s_sync || i == 0, s_en, s);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
